// File: rtl/pm_resp.sv
// pm_resp: program memory with boot loader and sequencer port.
// Boots words from the loader, then serves 1-cycle reads and writes.
module pm_resp #(
  parameter int PM_AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps_pm_cslt,
  input  logic        ps_pm_wrb,
  input  logic [15:0] ps_pm_add,
  input  logic [31:0] ps_pm_wdt,
  output logic [31:0] pm_ps_op,
  output logic        pm_ps_vld,
  output logic        pm_ps_busy,
  output logic        pm_ps_err,
  input  logic        bt_vld,
  input  logic [31:0] bt_dt,
  input  logic        bt_last,
  output logic        bt_rdy
);

  localparam int DEPTH = 1 << PM_AW;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [PM_AW-1:0] ld_ptr_q, ld_ptr_d;
  logic [31:0]      op_q, op_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic [31:0]      mem_q [DEPTH];
  logic             mem_we;
  logic [PM_AW-1:0] mem_wa;
  logic [31:0]      mem_wd;

  logic             bt_xfer;
  logic             ps_in_rng;
  logic             ps_rd;
  logic             ps_wr;
  logic [PM_AW-1:0] ps_idx;

  // Decode the current handshake and sequencer access
  always_comb begin
    bt_xfer   = (state_q == BOOT) && bt_vld;
    ps_in_rng = (ps_pm_add >> PM_AW) == 16'd0;
    ps_idx    = ps_pm_add[PM_AW-1:0];
    ps_rd     = (state_q == RUN) && ps_pm_cslt && !ps_pm_wrb;
    ps_wr     = (state_q == RUN) && ps_pm_cslt && ps_pm_wrb;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave BOOT after the last word or a full memory
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: begin
        if (bt_xfer && (bt_last || ld_ptr_q == '1)) begin
          state_d = RUN;
        end
      end
      RUN: state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Outputs driven from state and registered read path
  always_comb begin
    bt_rdy     = (state_q == BOOT);
    pm_ps_busy = (state_q == BOOT);
    pm_ps_op   = op_q;
    pm_ps_vld  = vld_q;
    pm_ps_err  = err_q;
  end

  // Datapath next values: load pointer, read data, error, write port
  always_comb begin
    ld_ptr_d = ld_ptr_q;
    op_d     = op_q;
    vld_d    = 1'b0;
    err_d    = err_q;
    mem_we   = 1'b0;
    mem_wa   = ps_idx;
    mem_wd   = ps_pm_wdt;
    if (bt_xfer) begin
      mem_we   = 1'b1;
      mem_wa   = ld_ptr_q;
      mem_wd   = bt_dt;
      ld_ptr_d = ld_ptr_q + PM_AW'(1);
    end
    if (ps_rd) begin
      vld_d = 1'b1;
      op_d  = ps_in_rng ? mem_q[ps_idx] : 32'h0;
    end
    if (ps_wr && ps_in_rng) begin
      mem_we = 1'b1;
    end
    if ((ps_rd || ps_wr) && !ps_in_rng) begin
      err_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_ptr_q <= '0;
      op_q     <= 32'h0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ld_ptr_q <= ld_ptr_d;
      op_q     <= op_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  // Memory array keeps contents across reset
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

endmodule

// File: tb/tb_pm_resp.sv
// tb_pm_resp: directed and random checks of pm_resp
// against a behavioural model of the boot/run rules.
module tb_pm_resp;

  localparam int AW = 8;
  localparam int N  = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps_pm_cslt;
  logic        ps_pm_wrb;
  logic [15:0] ps_pm_add;
  logic [31:0] ps_pm_wdt;
  logic [31:0] pm_ps_op;
  logic        pm_ps_vld;
  logic        pm_ps_busy;
  logic        pm_ps_err;
  logic        bt_vld;
  logic [31:0] bt_dt;
  logic        bt_last;
  logic        bt_rdy;

  pm_resp #(.PM_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps_pm_cslt(ps_pm_cslt),
    .ps_pm_wrb (ps_pm_wrb),
    .ps_pm_add (ps_pm_add),
    .ps_pm_wdt (ps_pm_wdt),
    .pm_ps_op  (pm_ps_op),
    .pm_ps_vld (pm_ps_vld),
    .pm_ps_busy(pm_ps_busy),
    .pm_ps_err (pm_ps_err),
    .bt_vld    (bt_vld),
    .bt_dt     (bt_dt),
    .bt_last   (bt_last),
    .bt_rdy    (bt_rdy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem   [N];
  bit          m_known [N];
  bit          m_boot  = 1'b1;
  int          m_ptr   = 0;
  logic [31:0] m_op    = 32'h0;
  bit          m_op_ok = 1'b0;
  bit          m_vld   = 1'b0;
  bit          m_err   = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare after edge
  task automatic tick(input bit r, input bit cs, input bit wr,
                      input logic [15:0] a, input logic [31:0] wd,
                      input bit bv, input logic [31:0] bd,
                      input bit bl);
    int idx;
    bit inr;
    rst        = r;
    ps_pm_cslt = cs;
    ps_pm_wrb  = wr;
    ps_pm_add  = a;
    ps_pm_wdt  = wd;
    bt_vld     = bv;
    bt_dt      = bd;
    bt_last    = bl;
    idx = int'(a) % N;
    inr = int'(a) < N;
    if (r) begin
      m_boot  = 1'b1;
      m_ptr   = 0;
      m_op    = 32'h0;
      m_op_ok = 1'b1;
      m_vld   = 1'b0;
      m_err   = 1'b0;
    end else if (m_boot) begin
      m_vld = 1'b0;
      if (bv) begin
        m_mem[m_ptr]   = bd;
        m_known[m_ptr] = 1'b1;
        if (bl || m_ptr == N - 1) m_boot = 1'b0;
        m_ptr = (m_ptr + 1) % N;
      end
    end else begin
      m_vld = 1'b0;
      if (cs) begin
        if (!inr) m_err = 1'b1;
        if (wr) begin
          if (inr) begin
            m_mem[idx]   = wd;
            m_known[idx] = 1'b1;
          end
        end else begin
          m_vld = 1'b1;
          if (inr) begin
            m_op    = m_mem[idx];
            m_op_ok = m_known[idx];
          end else begin
            m_op    = 32'h0;
            m_op_ok = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check("busy", 32'(pm_ps_busy), 32'(m_boot));
    check("bt_rdy", 32'(bt_rdy), 32'(m_boot));
    check("vld", 32'(pm_ps_vld), 32'(m_vld));
    check("err", 32'(pm_ps_err), 32'(m_err));
    if (m_op_ok) check("op", pm_ps_op, m_op);
  endtask

  task automatic idle();
    tick(0, 0, 0, 16'h0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic do_rst();
    tick(1, 0, 0, 16'h0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic boot_w(input logic [31:0] d, input bit last);
    tick(0, 0, 0, 16'h0, 32'h0, 1, d, last);
  endtask

  task automatic rd(input logic [15:0] a);
    tick(0, 1, 0, a, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    tick(0, 1, 1, a, d, 0, 32'h0, 0);
  endtask

  logic [31:0] four_w [4];

  initial begin
    four_w = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < N; i++) m_known[i] = 1'b0;

    // Reset state
    do_rst();
    do_rst();
    check("rst_op", pm_ps_op, 32'h0);
    check("rst_busy", 32'(pm_ps_busy), 32'd1);

    // Boot four words, last on the fourth, then read them back
    for (int i = 0; i < 4; i++) boot_w(four_w[i], i == 3);
    check("boot4_busy", 32'(pm_ps_busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(16'(i));
      check("boot4_rd", pm_ps_op, four_w[i]);
      check("boot4_vld", 32'(pm_ps_vld), 32'd1);
    end
    idle();

    // Sequencer accesses during BOOT are ignored
    do_rst();
    wr(16'h1, 32'hBAD0BAD0);
    rd(16'h2);
    rd(16'h0100);
    wr(16'h0100, 32'h1234);
    check("boot_cs_vld", 32'(pm_ps_vld), 32'd0);
    check("boot_cs_err", 32'(pm_ps_err), 32'd0);
    boot_w(32'h55, 1);
    rd(16'h1);
    check("boot_cs_mem1", pm_ps_op, 32'h22);
    rd(16'h0);
    check("boot_cs_mem0", pm_ps_op, 32'h55);

    // Full 256-word boot without bt_last
    do_rst();
    for (int i = 0; i < N; i++) begin
      boot_w(32'hC000_0000 | 32'(i * 7), 0);
      if (i < N - 1) check("full_busy", 32'(pm_ps_busy), 32'd1);
    end
    check("full_run", 32'(pm_ps_busy), 32'd0);
    boot_w(32'hFFFF_FFFF, 0);
    rd(16'h0);
    check("full_mem0", pm_ps_op, 32'hC000_0000);
    rd(16'hFF);
    check("full_mem255", pm_ps_op, 32'hC000_0000 | 32'(255 * 7));

    // Write then read same address on the next cycle
    wr(16'h5, 32'hDEADBEEF);
    check("wr_vld", 32'(pm_ps_vld), 32'd0);
    rd(16'h5);
    check("raw", pm_ps_op, 32'hDEADBEEF);

    // Out-of-range read sets sticky error
    rd(16'h0100);
    check("oor_op", pm_ps_op, 32'h0);
    check("oor_vld", 32'(pm_ps_vld), 32'd1);
    check("oor_err", 32'(pm_ps_err), 32'd1);
    wr(16'h6, 32'h66);
    rd(16'h6);
    idle();
    check("err_sticky", 32'(pm_ps_err), 32'd1);
    check("op_hold", pm_ps_op, 32'h66);

    // Randomized traffic with occasional reset and reboot
    for (int c = 0; c < 3000; c++) begin
      bit          r;
      logic [15:0] a;
      r = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 7) == 0) ?
          16'($urandom_range(256, 65535)) :
          16'($urandom_range(0, 255));
      tick(r, 1'($urandom), 1'($urandom), a, $urandom,
           1'($urandom), $urandom,
           $urandom_range(0, 15) == 0);
    end

    // Reset mid-boot restarts from address 0
    do_rst();
    boot_w(32'h1111, 0);
    boot_w(32'h2222, 0);
    do_rst();
    boot_w(32'hAA, 1);
    rd(16'h0);
    check("reboot_mem0", pm_ps_op, 32'hAA);
    rd(16'h1);
    check("reboot_mem1", pm_ps_op, 32'h2222);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
